// File: rtl/adc_ch_avg.sv
// Per-channel oversampling averager: edge-detected EOC capture, then 2^osr accumulate/publish per channel.
// Optional out-of-window flags are built when ADC_AVG_WINDOW_EN is defined.
module adc_ch_avg #(
  parameter int DW    = 12,
  parameter int OSR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             eoc,
  input  logic [DW-1:0]    adc_data,
  input  logic [2:0]       ch,
  input  logic [OSR_W-1:0] osr,
  input  logic             clr,
  input  logic [2:0]       rd_ch,
  output logic [DW-1:0]    rd_data,
  output logic [7:0]       done,
  input  logic [7:0]       ack,
  output logic             irq
`ifdef ADC_AVG_WINDOW_EN
  ,
  input  logic [DW-1:0]    win_lo,
  input  logic [DW-1:0]    win_hi,
  output logic [7:0]       win_out
`endif
);

  localparam int AW = DW + 4;

  logic             eoc_q;
  logic             cap_v_q;
  logic [2:0]       cap_ch_q;
  logic [DW-1:0]    cap_data_q;
  logic [2:0]       osr_eff_q, osr_eff_d;
  logic             osr_chg_q;
  logic [AW-1:0]    acc_q [8];
  logic [3:0]       cnt_q [8];
  logic [DW-1:0]    avg_q [8];
  logic [7:0]       done_q, done_d;
  logic             irq_q, irq_d;

  logic             smp_evt;
  logic [AW-1:0]    sum;
  logic [4:0]       win_len;
  logic [3:0]       cnt_max;
  logic             last;
  logic             upd;
  logic             pub;
  logic [DW-1:0]    avg_new;
  logic [7:0]       set_vec;

  assign smp_evt   = en & eoc & ~eoc_q;
  assign osr_eff_d = (int'(osr) > 4) ? 3'd4 : osr[2:0];

  always_comb begin
    sum     = acc_q[cap_ch_q] + AW'(cap_data_q);
    win_len = 5'd1 << osr_eff_q;
    cnt_max = 4'(win_len - 5'd1);
    last    = (cnt_q[cap_ch_q] == cnt_max);
    // The first cycle after an osr change flushes windows, so its update is dropped.
    upd     = cap_v_q & ~osr_chg_q;
    pub     = upd & last;
    avg_new = DW'(sum >> osr_eff_q);
    set_vec = pub ? (8'd1 << cap_ch_q) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_q      <= 1'b0;
      cap_v_q    <= 1'b0;
      cap_ch_q   <= '0;
      cap_data_q <= '0;
      osr_eff_q  <= '0;
      osr_chg_q  <= 1'b0;
    end else begin
      eoc_q     <= eoc;
      cap_v_q   <= smp_evt & ~clr;
      osr_eff_q <= osr_eff_d;
      osr_chg_q <= (osr_eff_d != osr_eff_q);
      if (smp_evt) begin
        cap_ch_q   <= ch;
        cap_data_q <= adc_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (clr || osr_chg_q) begin
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (upd) begin
      if (last) begin
        acc_q[cap_ch_q] <= '0;
        cnt_q[cap_ch_q] <= '0;
      end else begin
        acc_q[cap_ch_q] <= sum;
        cnt_q[cap_ch_q] <= cnt_q[cap_ch_q] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) avg_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) avg_q[i] <= '0;
    end else if (pub) begin
      avg_q[cap_ch_q] <= avg_new;
    end
  end

`ifdef ADC_AVG_WINDOW_EN
  logic [7:0] win_q, win_d;
  logic [7:0] win_set;
  logic       win_hit;

  always_comb begin
    win_hit = (avg_new < win_lo) | (avg_new > win_hi);
    win_set = win_hit ? set_vec : 8'd0;
    win_d   = clr ? 8'd0 : ((win_q & ~ack) | win_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  assign win_out = win_q;
  assign irq_d   = ~clr & (pub | (|win_set));
`else
  assign irq_d   = ~clr & pub;
`endif

  // Set beats a simultaneous write-one-to-clear.
  assign done_d = clr ? 8'd0 : ((done_q & ~ack) | set_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      irq_q  <= irq_d;
    end
  end

  assign rd_data = avg_q[rd_ch];
  assign done    = done_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_adc_ch_avg.sv
// Self-checking bench for adc_ch_avg: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a sample-level averaging model.
module tb_adc_ch_avg;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          eoc = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [2:0]    ch = '0;
  logic [2:0]    osr = '0;
  logic          clr = 1'b0;
  logic [2:0]    rd_ch = '0;
  logic [DW-1:0] rd_data;
  logic [7:0]    done;
  logic [7:0]    ack = '0;
  logic          irq;
`ifdef ADC_AVG_WINDOW_EN
  logic [DW-1:0] win_lo = '0;
  logic [DW-1:0] win_hi = '1;
  logic [7:0]    win_out;
`endif

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  bit rnd_rd = 0;

  adc_ch_avg #(.DW(DW), .OSR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .eoc(eoc), .adc_data(adc_data), .ch(ch),
    .osr(osr), .clr(clr), .rd_ch(rd_ch), .rd_data(rd_data), .done(done),
    .ack(ack), .irq(irq)
`ifdef ADC_AVG_WINDOW_EN
    , .win_lo(win_lo), .win_hi(win_hi), .win_out(win_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running sum and sample count per channel; a window
  // closes when it holds 2**osr samples and its average is sum/count.
  int       m_sum [8];
  int       m_n   [8];
  int       m_avg [8];
  bit [7:0] m_done;
  bit       m_irq;
  bit [7:0] m_win;
  int       m_osr;
  bit       m_flush;
  bit       m_prev_eoc;
  bit       m_pend;
  int       m_pc, m_pd;
  int       t_osr;
  bit [7:0] t_set, t_wset;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin m_sum[i] = 0; m_n[i] = 0; m_avg[i] = 0; end
      m_done = 0; m_irq = 0; m_win = 0; m_osr = 0; m_flush = 0;
      m_prev_eoc = 0; m_pend = 0; m_pc = 0; m_pd = 0;
    end else begin
      t_osr  = (osr > 4) ? 4 : int'(osr);
      t_set  = 0;
      t_wset = 0;
      m_irq  = 0;
      if (clr) begin
        for (int i = 0; i < 8; i++) begin m_sum[i] = 0; m_n[i] = 0; m_avg[i] = 0; end
        m_done = 0;
        m_win  = 0;
      end else begin
        if (m_flush) begin
          for (int i = 0; i < 8; i++) begin m_sum[i] = 0; m_n[i] = 0; end
        end else if (m_pend) begin
          m_sum[m_pc] += m_pd;
          m_n[m_pc]   += 1;
          if (m_n[m_pc] == (1 << m_osr)) begin
            m_avg[m_pc] = m_sum[m_pc] / m_n[m_pc];
            t_set[m_pc] = 1'b1;
`ifdef ADC_AVG_WINDOW_EN
            if (m_avg[m_pc] < int'(win_lo) || m_avg[m_pc] > int'(win_hi)) t_wset[m_pc] = 1'b1;
`endif
            m_sum[m_pc] = 0;
            m_n[m_pc]   = 0;
          end
        end
        m_done = (m_done & ~ack) | t_set;
        m_win  = (m_win & ~ack) | t_wset;
        m_irq  = (t_set != 0) || (t_wset != 0);
      end
      m_flush    = (t_osr != m_osr);
      m_osr      = t_osr;
      m_pend     = !clr && en && eoc && !m_prev_eoc;
      m_pc       = int'(ch);
      m_pd       = int'(adc_data);
      m_prev_eoc = eoc;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      check("rd_data", 32'(rd_data), 32'(m_avg[rd_ch]));
      check("done", 32'(done), 32'(m_done));
      check("irq", 32'(irq), 32'(m_irq));
`ifdef ADC_AVG_WINDOW_EN
      check("win_out", 32'(win_out), 32'(m_win));
`endif
      if (irq) irq_cnt++;
    end
  end

  // One conversion: eoc high for 'hold' cycles then low for 'gap' cycles.
  // a/cl are applied for exactly the cycle whose closing edge publishes.
  task automatic conv(input int c, input int d, input int hold, input int gap,
                      input logic [7:0] a, input logic cl);
    ch       = 3'(c);
    adc_data = DW'(d);
    for (int i = 0; i < hold + gap; i++) begin
      eoc = (i < hold);
      ack = (i == 1) ? a : 8'd0;
      clr = (i == 1) ? cl : 1'b0;
      if (rnd_rd) rd_ch = 3'($urandom_range(0, 7));
      if (i >= hold) adc_data = DW'($urandom);
      @(negedge clk);
    end
    ack = 8'd0;
    clr = 1'b0;
  endtask

  task automatic smp(input int c, input int d);
    conv(c, d, 1, 2, 8'd0, 1'b0);
  endtask

  task automatic peek(input int c);
    rd_ch = 3'(c);
    #1;
  endtask

  task automatic set_osr(input int o);
    osr = 3'(o);
    repeat (3) @(negedge clk);
  endtask

  int irq0;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    set_osr(0);

    // Single sample, eoc held 5 cycles: exactly one publish.
    irq0 = irq_cnt;
    conv(2, 'h5A5, 5, 3, 8'd0, 1'b0);
    peek(2);
    check("single_avg", 32'(rd_data), 32'h5A5);
    check("single_done", 32'(done), 32'h04);
    check("single_irq_pulses", 32'(irq_cnt - irq0), 32'd1);

    // Four-sample average on ch 5.
    set_osr(2);
    smp(5, 100); smp(5, 101); smp(5, 102);
    check("avg4_done5_early", 32'(done[5]), 32'd0);
    smp(5, 104);
    peek(5);
    check("avg4_value", 32'(rd_data), 32'd101);
    check("avg4_done5", 32'(done[5]), 32'd1);

    // Interleaved full-scale on ch 0 and 7.
    set_osr(4);
    irq0 = irq_cnt;
    for (int i = 0; i < 16; i++) begin
      conv(0, 'hFFF, 1, 1, 8'd0, 1'b0);
      conv(7, 'hFFF, 1, 1, 8'd0, 1'b0);
    end
    repeat (2) @(negedge clk);
    peek(0);
    check("full_ch0", 32'(rd_data), 32'hFFF);
    peek(7);
    check("full_ch7", 32'(rd_data), 32'hFFF);
    check("full_irq_pulses", 32'(irq_cnt - irq0), 32'd2);

    // osr change mid-window discards the partial window.
    set_osr(3);
    for (int i = 0; i < 5; i++) smp(1, 1000 + i);
    set_osr(1);
    smp(1, 10); smp(1, 20);
    peek(1);
    check("osrchg_avg", 32'(rd_data), 32'd15);
    check("osrchg_done1", 32'(done[1]), 32'd1);

    // ack/set collision, then clr against a publish.
    set_osr(0);
    ack = 8'hFF;
    @(negedge clk);
    ack = 8'h00;
    conv(3, 'h123, 1, 3, 8'h08, 1'b0);
    check("collide_done", 32'(done), 32'h08);
    conv(4, 'h321, 1, 3, 8'h00, 1'b1);
    check("clr_done", 32'(done), 32'h00);
    peek(4);
    check("clr_avg4", 32'(rd_data), 32'h0);
    peek(3);
    check("clr_avg3", 32'(rd_data), 32'h0);

`ifdef ADC_AVG_WINDOW_EN
    win_lo = 'h100;
    win_hi = 'h800;
    @(negedge clk);
    smp(4, 'h0FF);
    smp(6, 'h400);
    check("window_out", 32'(win_out), 32'h10);
`endif

    // Asynchronous reset mid-window.
    set_osr(2);
    smp(6, 500); smp(6, 700);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done", 32'(done), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    peek(6);
    check("arst_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    smp(6, 4); smp(6, 8); smp(6, 12); smp(6, 16);
    peek(6);
    check("arst_new_window", 32'(rd_data), 32'd10);

    // Randomized traffic against the model.
    rnd_rd = 1;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) begin
        osr = 3'($urandom_range(0, 7));
`ifdef ADC_AVG_WINDOW_EN
        win_lo = DW'($urandom_range(0, 'h7FF));
        win_hi = DW'($urandom_range('h800, 'hFFF));
`endif
      end
      if ($urandom_range(0, 99) < 3) osr = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) != 0);
      conv($urandom_range(0, 7), $urandom_range(0, 'hFFF),
           $urandom_range(1, 4), $urandom_range(1, 3),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0,
           ($urandom_range(0, 99) == 0));
    end
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_ch_avg.md
# adc_ch_avg

Per-channel oversampling averager that sits directly downstream of the SAR ADC controller. It takes the converter's end-of-conversion strobe, the raw 12-bit result and the active channel number. It accumulates 2^osr samples per channel across up to 8 channels, then publishes a truncated average per channel with sticky done flags and a single-cycle interrupt pulse. Firmware reads averages through a channel-indexed read port instead of draining raw samples.

## Interface
Parameters:
- `DW`, 12, sample width.
- `OSR_W`, 3, width of `osr`. The legal `osr` range is 0..4, so accumulators are `DW+4` bits wide.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; when low, incoming conversions are ignored and all state holds.
- `eoc`  in  1  end-of-conversion level from the ADC controller; may stay high for several `clk` cycles.
- `adc_data`  in  DW  conversion result; valid while `eoc` is high.
- `ch`  in  3  channel of the current conversion; stable while `eoc` is high.
- `osr`  in  OSR_W  log2 of the oversampling ratio. Values above 4 are clamped to 4.
- `clr`  in  1  synchronous clear of all accumulators, counters and done flags.
- `rd_ch`  in  3  read-port channel select.
- `rd_data`  out  DW  last published average of `rd_ch`; combinational mux.
- `done`  out  8  sticky per-channel flag: a new average has been published.
- `ack`  in  8  write-one-to-clear for `done`.
- `irq`  out  1  one-cycle pulse whenever any channel publishes.

## Operation
- **Edge detect.** `eoc_q` registers `eoc`. A sample event is `en & eoc & ~eoc_q`, so each conversion counts exactly once regardless of how long `eoc` stays high.
- **Stage 1 (capture).** On a sample event, register `cap_v=1`, `cap_ch=ch` and `cap_data=adc_data`. Otherwise `cap_v=0`.
- **Stage 2 (accumulate).** When `cap_v` is set:
  - `sum = acc[cap_ch] + cap_data`, computed `DW+4` bits wide with no overflow possible (16×4095 = 65520).
  - If `cnt[cap_ch] == (1<<osr_eff)-1`:
    - `avg[cap_ch] <= sum >> osr_eff` (truncation, no rounding).
    - `acc` and `cnt` for that channel go to 0.
    - `done[cap_ch] <= 1` and `irq <= 1`.
  - Otherwise `acc <= sum` and `cnt <= cnt+1`.
- **osr = 0.** Every sample publishes immediately and `avg` equals the sample.
- **osr change.** `osr_eff` is `osr` clamped to 4 and registered. Any change of `osr_eff` clears every `acc` and `cnt` on the following cycle and discards any Stage 2 update in that cycle. `avg` and `done` are kept.
- **clr.** Clears `acc`, `cnt`, `done`, `avg`, and the pipeline valids. It has priority over everything else, including a Stage 2 publish in the same cycle.
- **ack vs. set.** If `ack[i]` and a publish on channel `i` happen in the same cycle, set wins.
- **en low.** Blocks new sample events. A capture already in Stage 1 still completes. `eoc_q` keeps tracking `eoc`, so a conversion that is already high when `en` rises is not counted.

## Timing
- **Reset values.** `rd_data` = 0 (all `avg` = 0), `done` = 0, `irq` = 0. All `acc`, `cnt`, `cap_v` and `eoc_q` are 0; `osr_eff` = 0.
- **Latency.** `eoc` rises and is sampled at edge k, then Stage 1 captures at edge k. `avg`, `done` and `irq` update at edge k+1 and are visible after it. `irq` is high for exactly one cycle.
- **Throughput.** The block accepts a new sample event every 2 cycles. The ADC produces `eoc` at the divided clock rate, which is always slower.
- **Read port.** `rd_data` follows `rd_ch` combinationally and reflects a publish in the cycle after edge k+1.
- **Mid-operation reset.** The async reset clears immediately. A partially accumulated window is lost.

## Configuration
- `ADC_AVG_WINDOW_EN` defined:
  - Adds input ports `win_lo[DW-1:0]` and `win_hi[DW-1:0]`, and output `win_out[7:0]`.
  - On each publish, `win_out[ch]` is set (sticky) if `avg < win_lo` or `avg > win_hi`.
  - `win_out[ch]` is cleared by the same `ack[ch]`, with set winning over ack.
  - `irq` additionally pulses on any new `win_out` set; this coincides with the publish pulse, so it remains one pulse.
  - `clr` clears `win_out`.
- Not defined: those ports and all comparator logic are absent, and behaviour is otherwise identical.

## Test plan
- **Single-sample path.** Reset, `osr=0`, `eoc` pulse held 5 cycles with `ch=2`, `adc_data=0x5A5` → exactly one publish; `avg[2]=0x5A5`, `done=8'h04`, one `irq` cycle at k+1.
- **Four-sample average.** `osr=2`, four conversions on ch 5 with values 100, 101, 102, 104 → after the 4th, `rd_data`(rd_ch=5) = 101 (407>>2). `done[5]` is not set after samples 1–3.
- **Interleaved channels at full scale.** `osr=4`, 16 samples each on ch 0 and ch 7, alternating, all 0xFFF → both publish 0xFFF; no overflow; two `irq` pulses.
- **osr change mid-window.** `osr=3`, 5 samples on ch 1, then change to `osr=1` → counters clear; the next 2 samples publish their average; the earlier 5 samples are discarded.
- **ack/set collision and clr priority.** `ack[3]` asserted in the same cycle as a ch 3 publish → `done[3]` stays 1. `clr` asserted in the same cycle as a publish → `done=0`, `avg=0`.
- **Window (with `ADC_AVG_WINDOW_EN`).** `win_lo=0x100`, `win_hi=0x800`, `osr=0`, samples 0x0FF on ch 4 and 0x400 on ch 6 → `win_out=8'h10`.
